// File: rtl/cabac_bypass_encoder.sv
// Purpose : CABAC multi-bin bypass (EP) encoder; folds 1-4 equiprobable bins per
//           cycle into m_low and emits bitstream bytes with lead-byte/0xFF-run/carry handling.
// Latency : a byte produced by an accepted group is on out_valid the cycle after acceptance;
//           backpressure: byte_out held while out_valid && !out_ready, in_ready low during a run.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   init              one-cycle slice-start pulse, same effect as reset
//   m_range           9-bit range, sampled only on an accepting cycle
//   bin_in, n_bin     bins (bit0 first) and count-1 of the group
//   in_valid/in_ready group handshake
//   byte_out, out_valid/out_ready   bitstream byte handshake
//   low_out, bits_left_out, num_buffered_out, buffered_byte_out
//                     live coder state for the terminate/finish block
`timescale 1ns/1ps
module cabac_bypass_encoder #(
  parameter int RUN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic [8:0]       m_range,
  input  logic [3:0]       bin_in,
  input  logic [1:0]       n_bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       byte_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      low_out,
  output logic [4:0]       bits_left_out,
  output logic [RUN_W-1:0] num_buffered_out,
  output logic [7:0]       buffered_byte_out
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [RUN_W-1:0] NB_SAT = '1;
  localparam logic [RUN_W-1:0] NB_ONE = RUN_W'(1);

  state_t           state_q, state_d;
  logic [31:0]      low_q, low_d;
  logic [4:0]       bits_left_q, bits_left_d;
  logic [RUN_W-1:0] num_buf_q, num_buf_d;
  logic [7:0]       buf_byte_q, buf_byte_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [7:0]       run_byte_q, run_byte_d;
  logic [7:0]       byte_q, byte_d;
  logic             out_valid_q, out_valid_d;

  logic             out_hs;
  logic             out_free;
  logic             accept;

  // Group arithmetic
  logic [2:0]       n_bins;
  logic [31:0]      low_grp;
  logic [4:0]       bl_grp;
  logic             need_wo;
  logic [4:0]       wo_shift;
  logic [8:0]       lead;
  logic [4:0]       bl_wo;
  logic [31:0]      low_wo;
  logic             carry;

  assign out_hs   = out_valid_q && out_ready;
  assign out_free = !out_valid_q || out_ready;

  // The output register must be free (or draining this cycle) before a group may
  // be taken, since a group can produce a byte. A saturated buffered-byte counter
  // stalls input until the finish block re-inits the coder.
  assign in_ready = (state_q == IDLE) && out_free && !init && (num_buf_q != NB_SAT);
  assign accept   = in_valid && in_ready;

  // Shifting low once per bin and adding the range for a one-bin is the same as
  // (low << n) + sum(bin_i * range * 2^(n-1-i)), with bin0 most significant.
  always_comb begin
    n_bins  = {1'b0, n_bin} + 3'd1;
    low_grp = low_q;
    for (int i = 0; i < 4; i++) begin
      if (i <= int'(n_bin)) begin
        low_grp = {low_grp[30:0], 1'b0} + (bin_in[i] ? {23'd0, m_range} : 32'd0);
      end
    end
    bl_grp   = bits_left_q - {2'b00, n_bins};
    // bits_left is at least 12 before a group, so one writeout suffices.
    need_wo  = (bl_grp < 5'd12);
    wo_shift = 5'd24 - bl_grp;
    lead     = 9'(low_grp >> wo_shift);
    carry    = lead[8];
    bl_wo    = bl_grp + 5'd8;
    low_wo   = low_grp & (32'hFFFF_FFFF >> bl_wo);
  end

  // Next-state / output logic
  always_comb begin
    state_d     = state_q;
    low_d       = low_q;
    bits_left_d = bits_left_q;
    num_buf_d   = num_buf_q;
    buf_byte_d  = buf_byte_q;
    run_cnt_d   = run_cnt_q;
    run_byte_d  = run_byte_q;
    byte_d      = byte_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
        end
        if (accept) begin
          low_d       = low_grp;
          bits_left_d = bl_grp;
          if (need_wo) begin
            low_d       = low_wo;
            bits_left_d = bl_wo;
            if (lead == 9'h0FF) begin
              // 0xFF may still absorb a carry: keep it pending.
              num_buf_d = num_buf_q + NB_ONE;
            end else if (num_buf_q == '0) begin
              buf_byte_d = lead[7:0];
              num_buf_d  = NB_ONE;
            end else begin
              // Carry is now resolved: release the lead byte and its 0xFF run.
              byte_d      = buf_byte_q + {7'd0, carry};
              out_valid_d = 1'b1;
              run_cnt_d   = num_buf_q - NB_ONE;
              run_byte_d  = carry ? 8'h00 : 8'hFF;
              buf_byte_d  = lead[7:0];
              num_buf_d   = NB_ONE;
              if (num_buf_q != NB_ONE) begin
                state_d = RUN;
              end
            end
          end
        end
      end

      RUN: begin
        // run_cnt counts run bytes not yet loaded into the output register;
        // the run ends once the last loaded byte is taken.
        if (out_hs) begin
          if (run_cnt_q != '0) begin
            byte_d    = run_byte_q;
            run_cnt_d = run_cnt_q - NB_ONE;
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || init) begin
      state_q     <= IDLE;
      low_q       <= 32'd0;
      bits_left_q <= 5'd23;
      num_buf_q   <= '0;
      buf_byte_q  <= 8'hFF;
      run_cnt_q   <= '0;
      run_byte_q  <= 8'h00;
      byte_q      <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      low_q       <= low_d;
      bits_left_q <= bits_left_d;
      num_buf_q   <= num_buf_d;
      buf_byte_q  <= buf_byte_d;
      run_cnt_q   <= run_cnt_d;
      run_byte_q  <= run_byte_d;
      byte_q      <= byte_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign byte_out          = byte_q;
  assign out_valid         = out_valid_q;
  assign low_out           = low_q;
  assign bits_left_out     = bits_left_q;
  assign num_buffered_out  = num_buf_q;
  assign buffered_byte_out = buf_byte_q;

endmodule

// File: tb/tb_cabac_bypass_encoder.sv
`timescale 1ns/1ps
module tb_cabac_bypass_encoder;

  localparam int RUN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             init = 1'b0;
  logic [8:0]       m_range = 9'd256;
  logic [3:0]       bin_in = 4'd0;
  logic [1:0]       n_bin = 2'd0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       byte_out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      low_out;
  logic [4:0]       bits_left_out;
  logic [RUN_W-1:0] num_buffered_out;
  logic [7:0]       buffered_byte_out;

  cabac_bypass_encoder #(.RUN_W(RUN_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .init              (init),
    .m_range           (m_range),
    .bin_in            (bin_in),
    .n_bin             (n_bin),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .byte_out          (byte_out),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .low_out           (low_out),
    .bits_left_out     (bits_left_out),
    .num_buffered_out  (num_buffered_out),
    .buffered_byte_out (buffered_byte_out)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         hs_count = 0;
  bit         rnd_ready = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];

  // Reference coder state (VTM BinEncoder bypass semantics)
  logic [31:0] m_low;
  int          m_bits;
  int unsigned m_nbuf;
  logic [7:0]  m_bb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_low  = 32'd0;
    m_bits = 23;
    m_nbuf = 0;
    m_bb   = 8'hFF;
    exp_q.delete();
  endtask

  // encodeBinsEP: low = (low << n) + value * range, then writeOut if needed.
  task automatic model_group(input logic [3:0] b, input logic [1:0] nb, input logic [8:0] r);
    int          n;
    logic [31:0] v;
    logic [31:0] lead;
    logic [7:0]  c;
    logic [7:0]  t;
    n = int'(nb) + 1;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v * 2 + {31'd0, b[i]};
    m_low  = (m_low << n) + v * {23'd0, r};
    m_bits = m_bits - n;
    if (m_bits < 12) begin
      lead   = m_low >> (24 - m_bits);
      m_bits = m_bits + 8;
      m_low  = m_low & (32'hFFFF_FFFF >> m_bits);
      if (lead == 32'hFF) begin
        m_nbuf++;
      end else if (m_nbuf == 0) begin
        m_bb   = lead[7:0];
        m_nbuf = 1;
      end else begin
        c = {7'd0, lead[8]};
        t = m_bb + c;
        exp_q.push_back(t);
        for (int k = 1; k < int'(m_nbuf); k++) begin
          t = 8'hFF + c;
          exp_q.push_back(t);
        end
        m_bb   = lead[7:0];
        m_nbuf = 1;
      end
    end
  endtask

  // Monitor: every byte handshake is compared against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && !init && out_valid && out_ready) begin
        hs_count++;
        rx_log.push_back(byte_out);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", byte_out, $time);
        end else begin
          chk("byte", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Called and returns at a negedge.
  task automatic send_group(input logic [3:0] b, input logic [1:0] nb, input logic [8:0] r);
    int waited;
    bit done;
    waited = 0;
    done   = 1'b0;
    bin_in   = b;
    n_bin    = nb;
    m_range  = r;
    in_valid = 1'b1;
    while (!done) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      #3;
      if (in_ready) begin
        done = 1'b1;
        model_group(b, nb, r);
      end else if (++waited > 3000) begin
        done = 1'b1;
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected acceptance", waited);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    bin_in   = $urandom_range(0, 15);
    m_range  = $urandom_range(0, 511);
    #1;
    chk("low", low_out, m_low);
    chk("bits_left", {27'd0, bits_left_out}, m_bits);
    chk("num_buffered", {16'd0, num_buffered_out}, m_nbuf);
    chk("buffered_byte", {24'd0, buffered_byte_out}, {24'd0, m_bb});
    @(negedge clk);
  endtask

  task automatic do_init();
    init = 1'b1;
    #1;
    chk("init_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    init = 1'b0;
    model_reset();
    rx_log.delete();
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk(name, exp_q.size(), 32'd0);
  endtask

  // Bins at 1-based positions 8,16,24,32,40,41 with range 510 give leads
  // 0x00, 0xFF, 0xFF, 0xFF, then a carry-bearing lead on the 11th group.
  task automatic carry_seq();
    logic [3:0] g;
    do_init();
    for (int k = 0; k < 11; k++) begin
      g = 4'b0000;
      if (k == 1 || k == 3 || k == 5 || k == 7 || k == 9) g = 4'b1000;
      if (k == 10) g = 4'b0001;
      send_group(g, 2'd3, 9'd510);
    end
  endtask

  int hs0;

  initial begin
    // Reset state
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_low", low_out, 32'd0);
    chk("rst_bits_left", {27'd0, bits_left_out}, 32'd23);
    chk("rst_num_buffered", {16'd0, num_buffered_out}, 32'd0);
    chk("rst_buffered_byte", {24'd0, buffered_byte_out}, 32'hFF);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Single four-bin group
    send_group(4'b1101, 2'd3, 9'd256);
    chk("t1_low", low_out, 32'h0000_0B00);
    chk("t1_bits_left", {27'd0, bits_left_out}, 32'd19);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);

    // Zero bins: first lead buffered, second releases one byte
    do_init();
    for (int k = 0; k < 3; k++) send_group(4'd0, 2'd3, 9'd256);
    chk("z_bits_left", {27'd0, bits_left_out}, 32'd19);
    chk("z_num_buffered", {16'd0, num_buffered_out}, 32'd1);
    chk("z_buffered_byte", {24'd0, buffered_byte_out}, 32'h00);
    chk("z_no_byte", hs_count, 32'd0);
    hs0 = hs_count;
    for (int k = 0; k < 2; k++) send_group(4'd0, 2'd3, 9'd256);
    drain("z_drain");
    chk("z_one_byte", hs_count - hs0, 32'd1);
    chk("z_byte_val", (rx_log.size() > 0) ? {24'd0, rx_log[rx_log.size()-1]} : 32'hDEAD, 32'h00);

    // Carry through three 0xFF leads
    carry_seq();
    drain("carry_drain");
    chk("carry_count", rx_log.size(), 32'd4);
    if (rx_log.size() == 4) begin
      chk("carry_b0", {24'd0, rx_log[0]}, 32'h01);
      chk("carry_b1", {24'd0, rx_log[1]}, 32'h00);
      chk("carry_b2", {24'd0, rx_log[2]}, 32'h00);
      chk("carry_b3", {24'd0, rx_log[3]}, 32'h00);
    end

    // Backpressure in the middle of a run
    out_ready = 1'b0;
    carry_seq();
    chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #3;
      chk("bp_hold_byte", {24'd0, byte_out}, 32'h00);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("bp_no_bubble", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    #3;
    chk("bp_run_done", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("bp_total", rx_log.size(), 32'd4);
    drain("bp_drain");

    // Reset while a run with three bytes left is pending
    out_ready = 1'b0;
    carry_seq();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("rr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rr_bits_left", {27'd0, bits_left_out}, 32'd23);
    chk("rr_num_buffered", {16'd0, num_buffered_out}, 32'd0);
    hs0 = hs_count;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("rr_no_bytes", hs_count - hs0, 32'd0);

    // Randomised groups with random backpressure
    do_init();
    rnd_ready = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      send_group(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 9'($urandom_range(256, 510)));
    end
    rnd_ready = 1'b0;
    drain("rnd_drain");
    #1;
    chk("final_low", low_out, m_low);
    chk("final_bits_left", {27'd0, bits_left_out}, m_bits);
    chk("final_num_buffered", {16'd0, num_buffered_out}, m_nbuf);
    chk("final_buffered_byte", {24'd0, buffered_byte_out}, {24'd0, m_bb});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cabac_bypass_encoder.md
Name: cabac_bypass_encoder

Overview:
- Encoder-side counterpart of the multi-bin bypass (EP) decoder in the VVC arithmetic coding path.
- Accepts groups of 1–4 equiprobable bins per cycle against a held 9-bit range, updates the low register, and emits bitstream bytes.
- Byte emission follows the VTM BinEncoder writeOut rule: a buffered lead byte, a run of 0xFF bytes, and carry propagation.
- Exports the live coder state so the terminate/finish block can flush the stream at end of slice.

Parameters:
- RUN_W, 16, width of the buffered-byte counter; saturation limit is 2^RUN_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- init  in  1  one-cycle pulse; restarts coder state (slice start).
- m_range  in  9  current range; held stable while bypass bins are coded.
- bin_in  in  4  bins, bit0 coded first.
- n_bin  in  2  number of bins minus 1: 0 = bin_in[0] only, 3 = all four.
- in_valid  in  1  bin group valid.
- in_ready  out  1  group accepted when in_valid && in_ready.
- byte_out  out  8  emitted bitstream byte.
- out_valid  out  1  byte_out valid.
- out_ready  in  1  downstream accepts byte on out_valid && out_ready.
- low_out  out  32  m_low register.
- bits_left_out  out  5  m_bitsLeft register.
- num_buffered_out  out  RUN_W  buffered-byte count.
- buffered_byte_out  out  8  buffered lead byte.

Behaviour:
- Reset (rst_n=0 at a clock edge) and init (init=1) have identical effect, and reset wins over everything:
  - low=0, bits_left=23, num_buffered=0, buffered_byte=0xFF.
  - out_valid=0, byte_out=0, internal run counter=0, FSM=IDLE.
  - Any byte or run in progress is discarded.
- in_ready=1 iff all of the following hold:
  - FSM=IDLE;
  - out_valid=0, or out_valid&&out_ready this cycle;
  - init=0;
  - num_buffered < 2^RUN_W-1.
- Accepted group, n = n_bin+1 (single cycle):
  - low' = (low<<n) + sum over i<n of bin_in[i]·m_range·2^(n-1-i), computed at 32 bits.
  - bits_left' = bits_left - n.
- Writeout occurs in the same cycle when bits_left' < 12. Since bits_left ≥ 12 before the group, at most one writeout per group.
  - lead = low' >> (24-bits_left') (9 bits incl. carry).
  - Then bits_left'' = bits_left'+8 and low'' = low' & (0xFFFFFFFF >> bits_left'').
- Lead-byte cases:
  - lead==0xFF: num_buffered += 1; no byte.
  - Otherwise, if num_buffered==0: buffered_byte = lead[7:0], num_buffered=1; no byte.
  - Otherwise, with carry = lead[8]:
    - register byte_out = (buffered_byte+carry)[7:0] and set out_valid=1;
    - run counter = num_buffered-1 and run_byte = (0xFF+carry)[7:0];
    - buffered_byte = lead[7:0], num_buffered=1;
    - FSM → RUN if run counter>0, else stays IDLE.
- Latency: a byte appears on out_valid the cycle after the accepting edge.
- RUN state:
  - On each out_ready handshake, load byte_out=run_byte and decrement the run counter.
  - When the last run byte is handshaken, go to IDLE.
  - in_ready stays 0 throughout RUN.
- Output register is held stable while out_valid && !out_ready. It is never overwritten, and there are no bubbles when out_ready stays 1.
- State outputs reflect the registers directly (post-edge values). They are valid for the finish block only when FSM=IDLE and out_valid=0.
- m_range is sampled only on an accepting cycle.
- When num_buffered is saturated, in_ready=0 until the finish block reinitialises via init.

Test Plan:
- Reset, then m_range=256 and bin_in=4'b1101, n_bin=3 → low=0x00000B00, bits_left=19, no byte, in_ready=1.
- After init, 12 zero bins (n_bin=3 ×3) → bits_left=19 (11 then +8), num_buffered=1, buffered_byte=0x00, no byte. Then 8 more zero bins (×2) → byte_out=0x00, one handshake only.
- Force three consecutive 0xFF lead bytes with m_range=510, then a carry-producing group → byte sequence buffered+1, 0x00, 0x00, 0x00. Every group and every byte must match the VTM BinEncoder bypass C model.
- Backpressure: out_ready=0 for 5 cycles mid-RUN → byte_out stable, in_ready=0. On release, the remaining run bytes arrive on consecutive cycles.
- rst_n=0 while in RUN with 3 bytes left → next cycle out_valid=0, bits_left=23, num_buffered=0, and no further bytes.
- Random 10k groups with random n_bin, random m_range in 256–510, and random out_ready → byte stream and final state outputs equal the C model exactly.
